// File: rtl/clk_div_pkg.sv
// clk_div_pkg: state encoding and default parameters shared by the clock divider files
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int DIV_RST_DEF = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/clk_div_byp_gate.sv
// clk_div_byp_gate: glitch-free clock gate, enable retimed on the falling source edge
module clk_div_byp_gate
  import clk_div_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  output logic clk_out
);
  logic byp_en_d, byp_en_q;
  // the gate enable follows the request
  always_comb byp_en_d = en;
  // enable only moves while clk_in is low, so the AND never chops a high phase
  always_ff @(negedge clk_in or negedge rst_n)
    if (!rst_n) byp_en_q <= 1'b0;
    else byp_en_q <= byp_en_d;
  assign clk_out = clk_in & byp_en_q;
endmodule

// File: rtl/clk_div_glitchfree.sv
// clk_div_glitchfree: runtime-programmable integer clock divider, ratio changes only at period boundaries
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge copy of the divided clock for 50% duty on odd ratios.
module clk_div_glitchfree
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_req,
  output logic             div_rdy,
  output logic             div_ack,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             clk_out
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  state_t state_d, state_q;
  logic [DIV_W-1:0] cnt_d, cnt_q, cur_div_d, cur_div_q, pend_div_d, pend_div_q, div_nx, half;
  logic div_rdy_d, div_rdy_q, div_ack_d, div_ack_q, clk_pos_d, clk_pos_q;
  logic boundary, apply, run_nx, long_nx, idle, byp_clk;
  // handshake, boundary detection and next-period bookkeeping
  always_comb begin
    idle = state_q == IDLE;
    boundary = idle || cur_div_q < TWO || cnt_q == cur_div_q - ONE;
    apply = !div_rdy_q && boundary;
    div_nx = apply ? pend_div_q : cur_div_q;
    half = cur_div_q >> 1;
    run_nx = en && div_nx != '0;
    long_nx = div_nx >= TWO;
    pend_div_d = div_req && div_rdy_q ? div_val : pend_div_q;
    div_rdy_d = div_rdy_q ? !div_req : boundary;
    div_ack_d = apply;
    cur_div_d = div_nx;
    state_d = boundary ? (run_nx ? RUN : IDLE) : (en ? RUN : DRAIN);
    cnt_d = !boundary ? cnt_q + ONE : (idle && run_nx && long_nx) ? div_nx - ONE : '0;
    clk_pos_d = !boundary ? cnt_d < half : !idle && run_nx && long_nx;
  end
  // all divider state advances on the rising source edge
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_div_q <= DIV_W'(DIV_RST);
      pend_div_q <= '0;
      div_rdy_q <= 1'b1;
      div_ack_q <= 1'b0;
      clk_pos_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_div_q <= pend_div_d;
      div_rdy_q <= div_rdy_d;
      div_ack_q <= div_ack_d;
      clk_pos_q <= clk_pos_d;
    end
  clk_div_byp_gate u_byp (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (running && cur_div_q == ONE),
    .clk_out(byp_clk)
  );
  assign div_rdy = div_rdy_q;
  assign div_ack = div_ack_q;
  assign cur_div = cur_div_q;
  assign running = state_q != IDLE;
`ifdef CLK_DIV_ODD_DUTY50_EN
  logic clk_neg_d, clk_neg_q;
  // only odd ratios get the half-cycle stretch; clk_pos is never high for ratio 0 or 1
  always_comb clk_neg_d = clk_pos_q && cur_div_q[0];
  // half-period delayed copy of clk_pos widens odd-ratio high time by half a source period
  always_ff @(negedge clk_in or negedge rst_n)
    if (!rst_n) clk_neg_q <= 1'b0;
    else clk_neg_q <= clk_neg_d;
  assign clk_out = clk_pos_q | clk_neg_q | byp_clk;
`else
  assign clk_out = clk_pos_q | byp_clk;
`endif
endmodule

// File: tb/tb_clk_div_glitchfree.sv
// tb_clk_div_glitchfree: table, directed and randomized checks of clk_div_glitchfree
module tb_clk_div_glitchfree;
  localparam int DIV_W = 8;
  localparam int HP = 10;
  typedef struct {
    int ratio;
    longint hi;
    longint lo;
  } vec_t;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic div_req = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic div_rdy, div_ack, running, clk_out;
  logic [DIV_W-1:0] cur_div;
  int checks = 0, errors = 0, edges = 0, acks = 0;
  longint last_t = 0, min_w = 1000000;
  bit mon_en = 1'b0;
  vec_t tbl[7];

  clk_div_glitchfree dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .div_val(div_val),
    .div_req(div_req),
    .div_rdy(div_rdy),
    .div_ack(div_ack),
    .cur_div(cur_div),
    .running(running),
    .clk_out(clk_out)
  );

  always #HP clk_in = ~clk_in;

  always @(clk_out) begin
    if (mon_en && $time - last_t < min_w) min_w = $time - last_t;
    last_t = $time;
    edges++;
  end

  always @(negedge clk_in) if (div_ack) acks++;

  function automatic longint exp_hi(input int n);
`ifdef CLK_DIV_ODD_DUTY50_EN
    if (n % 2 == 1) return longint'(n * HP);
`endif
    return n == 1 ? HP : longint'((n / 2) * 2 * HP);
  endfunction

  function automatic longint exp_lo(input int n);
    return longint'(n * 2 * HP) - exp_hi(n);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_lvl(input logic v, input string nm);
    for (int i = 0; i < 4000 && clk_out !== v; i++) #2;
    if (clk_out !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: clk_out stuck at %b while waiting for %b", nm, clk_out, v);
    end
  endtask

  task automatic meas(input string nm, output longint hi, output longint lo);
    longint t0, t1;
    wait_lvl(1'b0, nm);
    wait_lvl(1'b1, nm);
    t0 = $time;
    wait_lvl(1'b0, nm);
    t1 = $time;
    wait_lvl(1'b1, nm);
    hi = t1 - t0;
    lo = $time - t1;
  endtask

  task automatic prog(input int v);
    for (int i = 0; i < 600 && !div_rdy; i++) cyc(1);
    div_val = DIV_W'(v);
    div_req = 1'b1;
    cyc(1);
    div_req = 1'b0;
    chk($sformatf("rdy_low_%0d", v), longint'(div_rdy), 0);
    for (int i = 0; i < 600 && !div_ack; i++) cyc(1);
    chk($sformatf("ack_seen_%0d", v), longint'(div_ack), 1);
    chk($sformatf("cur_div_%0d", v), longint'(cur_div), v);
    cyc(1);
    chk($sformatf("ack_pulse_%0d", v), longint'(div_ack), 0);
    chk($sformatf("rdy_back_%0d", v), longint'(div_rdy), 1);
  endtask

  initial begin
    longint hi, lo, t0;
    int n;
    tbl[0] = '{6, 60, 60};
    tbl[2] = '{4, 40, 40};
    tbl[5] = '{1, 10, 10};
    tbl[6] = '{2, 20, 20};
`ifdef CLK_DIV_ODD_DUTY50_EN
    tbl[1] = '{5, 50, 50};
    tbl[3] = '{3, 30, 30};
    tbl[4] = '{7, 70, 70};
`else
    tbl[1] = '{5, 40, 60};
    tbl[3] = '{3, 20, 40};
    tbl[4] = '{7, 60, 80};
`endif
    en = 1'b1;
    #41;
    chk("rst_clk_out", longint'(clk_out), 0);
    chk("rst_cur_div", longint'(cur_div), 2);
    chk("rst_div_rdy", longint'(div_rdy), 1);
    chk("rst_div_ack", longint'(div_ack), 0);
    chk("rst_running", longint'(running), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("start_running", longint'(running), 1);
    chk("start_low", longint'(clk_out), 0);
    cyc(1);
    chk("first_rise", longint'(clk_out), 1);
    meas("div2", hi, lo);
    chk("div2_hi", hi, 20);
    chk("div2_lo", lo, 20);

    foreach (tbl[i]) begin
      prog(tbl[i].ratio);
      meas($sformatf("tbl_%0d", tbl[i].ratio), hi, lo);
      chk($sformatf("tbl_hi_%0d", tbl[i].ratio), hi, tbl[i].hi);
      chk($sformatf("tbl_lo_%0d", tbl[i].ratio), lo, tbl[i].lo);
    end

    prog(4);
    wait_lvl(1'b0, "drain");
    wait_lvl(1'b1, "drain");
    t0 = $time;
    cyc(1);
    en = 1'b0;
    wait_lvl(1'b0, "drain");
    chk("drain_hi", $time - t0, 40);
    cyc(1);
    chk("drain_running", longint'(running), 1);
    cyc(1);
    chk("drain_idle", longint'(running), 0);
    n = edges;
    cyc(10);
    chk("idle_quiet", longint'(edges - n), 0);
    chk("idle_low", longint'(clk_out), 0);
    en = 1'b1;
    cyc(1);
    chk("rerun_running", longint'(running), 1);
    chk("rerun_low", longint'(clk_out), 0);
    cyc(1);
    chk("rerun_rise", longint'(clk_out), 1);

    mon_en = 1'b1;
    min_w = 1000000;
    prog(3);
    cyc(7);
    prog(1);
    cyc(7);
    prog(0);
    n = edges;
    cyc(20);
    chk("div0_quiet", longint'(edges - n), 0);
    chk("div0_low", longint'(clk_out), 0);
    chk("div0_idle", longint'(running), 0);
    prog(2);
    meas("div0to2", hi, lo);
    chk("div0to2_hi", hi, 20);
    chk("div0to2_lo", lo, 20);
    mon_en = 1'b0;
    checks++;
    if (min_w < HP) begin
      errors++;
      $display("FAIL min_pulse: got %0d, expected at least %0d", min_w, HP);
    end

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(24, 1));
      prog(n);
      meas($sformatf("rand_%0d", n), hi, lo);
      chk($sformatf("rand_hi_%0d", n), hi, exp_hi(n));
      chk($sformatf("rand_lo_%0d", n), lo, exp_lo(n));
    end

    prog(200);
    wait_lvl(1'b1, "long_hi");
    div_val = 8'd9;
    div_req = 1'b1;
    cyc(1);
    div_req = 1'b0;
    chk("pend_rdy", longint'(div_rdy), 0);
    chk("pend_hi", longint'(clk_out), 1);
    n = acks;
    #2 rst_n = 1'b0;
    #2;
    chk("mid_rst_clk_out", longint'(clk_out), 0);
    chk("mid_rst_cur_div", longint'(cur_div), 2);
    chk("mid_rst_rdy", longint'(div_rdy), 1);
    chk("mid_rst_running", longint'(running), 0);
    rst_n = 1'b1;
    cyc(30);
    chk("no_stale_ack", longint'(acks - n), 0);
    chk("post_rst_div", longint'(cur_div), 2);
    meas("post_rst", hi, lo);
    chk("post_rst_hi", hi, 20);
    chk("post_rst_lo", lo, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
